apb_req_master: RTL
===================

APB_REQ_MASTER -- requirements
Module: apb_req_master

Interface
REQ-001 The block SHALL have parameter ADDR_WD, default 32, meaning APB address width.
REQ-002 The block SHALL have parameter DATA_WD, default 32, meaning APB data width.
REQ-003 The block SHALL have parameter STRB_WD, default 4, meaning byte-strobe width (DATA_WD/8).
REQ-004 The block SHALL have parameter PROT_WD, default 3, meaning protection-field width.
REQ-005 The block SHALL have parameter TIMEOUT_CYC, default 256, meaning the ACCESS-wait limit in cycles (used only under APB_MASTER_TIMEOUT_EN).
REQ-006 b_pclk  input  1  clock; all logic on rising edge.
REQ-007 b_prst_n  input  1  reset, asynchronous, active-low.
REQ-008 cmd_valid  input  1  command present; cmd_ready  output  1  command accepted when both high.
REQ-009 cmd_write  input  1  1=write, 0=read; cmd_addr  input  ADDR_WD  address; cmd_wdata  input  DATA_WD  write data; cmd_strb  input  STRB_WD  strobes; cmd_prot  input  PROT_WD  protection.
REQ-010 rsp_valid  output  1  response present; rsp_ready  input  1  response consumed when both high.
REQ-011 rsp_rdata  output  DATA_WD  read data; rsp_slverr  output  1  error; rsp_timeout  output  1  access aborted by watchdog.
REQ-012 b_psel, b_penable, b_pwrite  output  1 each; b_paddr  output  ADDR_WD; b_pwdata  output  DATA_WD; b_pstrb  output  STRB_WD; b_pprot  output  PROT_WD: APB requester signals.
REQ-013 b_prdata  input  DATA_WD; b_pready  input  1; b_pslverr  input  1: APB completer signals.

Function
REQ-014 The FSM SHALL have states IDLE, SETUP, ACCESS, RESP; all outputs registered or decoded from state only.
REQ-015 cmd_ready SHALL be 1 exactly in IDLE; a handshake in IDLE SHALL latch all cmd_* fields and move to SETUP next cycle.
REQ-016 SETUP SHALL drive b_psel=1, b_penable=0 for exactly one cycle, then ACCESS.
REQ-017 ACCESS SHALL drive b_psel=1, b_penable=1 and remain until b_pready=1 is sampled.
REQ-018 b_paddr, b_pwrite, b_pwdata, b_pstrb, b_pprot SHALL hold the latched values, unchanged, from SETUP through the final ACCESS cycle.
REQ-019 For reads, b_pstrb SHALL be all zeros regardless of cmd_strb; b_pwdata SHALL be don't-care but stable.
REQ-020 On the ACCESS cycle with b_pready=1: capture b_prdata (reads) or zero (writes) into rsp_rdata, b_pslverr into rsp_slverr, rsp_timeout=0, go to RESP.
REQ-021 RESP SHALL drive b_psel=0, b_penable=0, rsp_valid=1; rsp_* SHALL stay stable until rsp_ready=1, then IDLE next cycle.
REQ-022 Minimum transaction period SHALL be 4 cycles (IDLE, SETUP, ACCESS, RESP) with zero wait states and rsp_ready held high.
REQ-023 cmd_valid SHALL be ignored outside IDLE; only one transaction outstanding at a time.
REQ-024 Outside SETUP/ACCESS, b_psel and b_penable SHALL be 0.

Reset
REQ-025 On b_prst_n=0, state SHALL become IDLE immediately; cmd_ready=1 after release; b_psel, b_penable, b_pwrite, rsp_valid, rsp_slverr, rsp_timeout=0; b_paddr, b_pwdata, b_pstrb, b_pprot, rsp_rdata=0; timeout counter=0.
REQ-026 Reset asserted mid-transaction SHALL abandon it with no response generated.

Configuration
REQ-027 Macro APB_MASTER_TIMEOUT_EN defined: a counter SHALL count ACCESS cycles with b_pready=0; if b_pready is still 0 on the TIMEOUT_CYC-th ACCESS cycle, the block SHALL go to RESP with rsp_slverr=1, rsp_timeout=1, rsp_rdata=0, deasserting b_psel/b_penable next cycle.
REQ-028 Counter SHALL clear on every entry to SETUP; b_pready=1 on the limit cycle SHALL complete normally.
REQ-029 Macro undefined: no counter; ACCESS waits indefinitely; rsp_timeout SHALL be tied 0.

Verification
REQ-030 Write addr 0x10, data 0xDEADBEEF, strb 0xF, pready=1 -> SETUP 1 cycle, ACCESS 1 cycle, rsp_valid with rsp_rdata=0, rsp_slverr=0.
REQ-031 Read addr 0x10, completer returns 0xDEADBEEF after 3 wait states -> ACCESS 4 cycles, b_pstrb=0, rsp_rdata=0xDEADBEEF.
REQ-032 Read with b_pslverr=1 at completion -> rsp_slverr=1; rsp_ready held 0 for 5 cycles -> rsp_* stable, b_psel=0 throughout.
REQ-033 cmd_valid held high continuously, 3 commands -> cmd_ready pulses once per 4 cycles, no overlap of SETUP phases.
REQ-034 APB_MASTER_TIMEOUT_EN, TIMEOUT_CYC=8, pready held 0 -> exactly 8 ACCESS cycles, then rsp_timeout=1, rsp_slverr=1.
REQ-035 b_prst_n pulsed low during ACCESS -> b_psel=0 immediately, no rsp_valid, next command runs normally.

Source files
------------

// File: rtl/apb_req_master.sv
// APB requester: accepts one command at a time, runs SETUP/ACCESS on APB and returns a response.
// Optional ACCESS watchdog enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_req_master #(
   parameter int ADDR_WD     = 32,
   parameter int DATA_WD     = 32,
   parameter int STRB_WD     = 4,
   parameter int PROT_WD     = 3,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic               b_pclk,
   input  logic               b_prst_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic               cmd_write,
   input  logic [ADDR_WD-1:0] cmd_addr,
   input  logic [DATA_WD-1:0] cmd_wdata,
   input  logic [STRB_WD-1:0] cmd_strb,
   input  logic [PROT_WD-1:0] cmd_prot,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [DATA_WD-1:0] rsp_rdata,
   output logic               rsp_slverr,
   output logic               rsp_timeout,
   output logic               b_psel,
   output logic               b_penable,
   output logic               b_pwrite,
   output logic [ADDR_WD-1:0] b_paddr,
   output logic [DATA_WD-1:0] b_pwdata,
   output logic [STRB_WD-1:0] b_pstrb,
   output logic [PROT_WD-1:0] b_pprot,
   input  logic [DATA_WD-1:0] b_prdata,
   input  logic               b_pready,
   input  logic               b_pslverr
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t state, state_nxt;
   logic   cmd_take;
   logic   acc_done;
   logic   to_hit;

   assign cmd_take = (state == IDLE) && cmd_valid;
   assign acc_done = (state == ACCESS) && b_pready;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int unsigned CNT_WD = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_WD-1:0] to_cnt;

   // Fires on the TIMEOUT_CYC-th ACCESS cycle still waiting; a ready on that cycle wins.
   assign to_hit = (state == ACCESS) && !b_pready && (to_cnt == CNT_WD'(TIMEOUT_CYC - 1));

   always_ff @(posedge b_pclk or negedge b_prst_n) begin
      if (!b_prst_n) begin
         to_cnt <= '0;
      end else if (cmd_take) begin
         to_cnt <= '0;
      end else if ((state == ACCESS) && !b_pready && !to_hit) begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   always_ff @(posedge b_pclk or negedge b_prst_n) begin
      if (!b_prst_n) begin
         rsp_timeout <= 1'b0;
      end else if (acc_done) begin
         rsp_timeout <= 1'b0;
      end else if (to_hit) begin
         rsp_timeout <= 1'b1;
      end
   end
`else
   // The watchdog is absent in this build, so TIMEOUT_CYC has no effect.
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYC;
   assign to_hit             = 1'b0;
   assign rsp_timeout        = 1'b0;
`endif

   always_ff @(posedge b_pclk or negedge b_prst_n) begin
      if (!b_prst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:   if (cmd_valid) state_nxt = SETUP;
         SETUP:  state_nxt = ACCESS;
         ACCESS: if (b_pready || to_hit) state_nxt = RESP;
         RESP:   if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = (state == IDLE);
      b_psel    = (state == SETUP) || (state == ACCESS);
      b_penable = (state == ACCESS);
      rsp_valid = (state == RESP);
   end

   always_ff @(posedge b_pclk or negedge b_prst_n) begin
      if (!b_prst_n) begin
         b_pwrite <= 1'b0;
         b_paddr  <= '0;
         b_pwdata <= '0;
         b_pstrb  <= '0;
         b_pprot  <= '0;
      end else if (cmd_take) begin
         b_pwrite <= cmd_write;
         b_paddr  <= cmd_addr;
         b_pwdata <= cmd_wdata;
         b_pstrb  <= cmd_write ? cmd_strb : '0;
         b_pprot  <= cmd_prot;
      end
   end

   always_ff @(posedge b_pclk or negedge b_prst_n) begin
      if (!b_prst_n) begin
         rsp_rdata  <= '0;
         rsp_slverr <= 1'b0;
      end else if (acc_done) begin
         rsp_rdata  <= b_pwrite ? '0 : b_prdata;
         rsp_slverr <= b_pslverr;
      end else if (to_hit) begin
         rsp_rdata  <= '0;
         rsp_slverr <= 1'b1;
      end
   end

endmodule
